// File: rtl/deserializer_pkg.sv
// Shared constants for the serial-to-parallel deserializer.
package deserializer_pkg;

   localparam int unsigned DESER_DATA_W_DEFAULT = 16;

   // Counter must reach DATA_W when a parity bit trails the data bits.
   function automatic int unsigned deser_cnt_w(input int unsigned data_w);
      return $clog2(data_w + 1);
   endfunction

   localparam int unsigned DESER_CNT_W = deser_cnt_w(DESER_DATA_W_DEFAULT);

endpackage

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel deserializer with a one-cycle word-valid pulse.
// Define DESERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module deserializer
   import deserializer_pkg::*;
#(
   parameter int unsigned DATA_W = DESER_DATA_W_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              data_i,
   input  logic              data_val_i,
   output logic [DATA_W-1:0] deser_data_o,
   output logic              deser_data_val_o,
`ifdef DESERIALIZER_PARITY_EN
   output logic              parity_err_o,
`endif
   output logic              busy_o
);

   localparam int unsigned CNT_W = deser_cnt_w(DATA_W);
`ifdef DESERIALIZER_PARITY_EN
   localparam int unsigned FRAME_LEN = DATA_W + 1;
`else
   localparam int unsigned FRAME_LEN = DATA_W;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              val_q,   val_d;
   logic              last_c;
`ifdef DESERIALIZER_PARITY_EN
   logic              perr_q,  perr_d;
`endif

   assign last_c = (cnt_q == LAST_CNT);

   // Next-state: count accepted bits, shift data bits, publish on the last bit.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      val_d   = 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      perr_d  = 1'b0;
`endif
      if (data_val_i) begin
         cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
`ifdef DESERIALIZER_PARITY_EN
         // The trailing bit is parity only; it is never shifted into the word.
         if (last_c) begin
            data_d = shift_q;
            val_d  = 1'b1;
            perr_d = ^{shift_q, data_i};
         end else begin
            shift_d = {shift_q[DATA_W-2:0], data_i};
         end
`else
         shift_d = {shift_q[DATA_W-2:0], data_i};
         if (last_c) begin
            data_d = shift_d;
            val_d  = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         val_q   <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         val_q   <= val_d;
`ifdef DESERIALIZER_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign deser_data_o     = data_q;
   assign deser_data_val_o = val_q;
   assign busy_o           = (cnt_q != '0);
`ifdef DESERIALIZER_PARITY_EN
   assign parity_err_o     = perr_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: frame-level model checked every cycle plus literal expectations.
module tb_deserializer;

   localparam int unsigned DATA_W = 16;
`ifdef DESERIALIZER_PARITY_EN
   localparam int unsigned FRAME_LEN = DATA_W + 1;
`else
   localparam int unsigned FRAME_LEN = DATA_W;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              data_i = 1'b0;
   logic              data_val_i = 1'b0;
   logic [DATA_W-1:0] deser_data_o;
   logic              deser_data_val_o;
   logic              busy_o;
`ifdef DESERIALIZER_PARITY_EN
   logic              parity_err_o;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   deserializer #(.DATA_W(DATA_W)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .data_i           (data_i),
      .data_val_i       (data_val_i),
      .deser_data_o     (deser_data_o),
      .deser_data_val_o (deser_data_val_o),
`ifdef DESERIALIZER_PARITY_EN
      .parity_err_o     (parity_err_o),
`endif
      .busy_o           (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Frame-level model: collect accepted bits; a full frame becomes a word.
   bit                q_bits[$];
   logic [DATA_W-1:0] m_word = '0;
   logic              m_val  = 1'b0;
   logic              m_perr = 1'b0;
   int                pulse_cyc[$];
   logic [DATA_W-1:0] pulse_word[$];

   always @(posedge clk_i) begin
      logic [DATA_W-1:0] w;
      bit                p;
      cyc++;
      if (!rst_i) begin
         q_bits.delete();
         m_word = '0;
         m_val  = 1'b0;
         m_perr = 1'b0;
      end else begin
         m_val  = 1'b0;
         m_perr = 1'b0;
         if (data_val_i) begin
            q_bits.push_back(data_i);
            if (q_bits.size() == FRAME_LEN) begin
               w = '0;
               p = 1'b0;
               for (int i = 0; i < int'(DATA_W); i++) begin
                  if (q_bits[i]) w = w + (DATA_W'(1) << (DATA_W - 1 - i));
                  p = p ^ q_bits[i];
               end
`ifdef DESERIALIZER_PARITY_EN
               p = p ^ q_bits[FRAME_LEN-1];
               m_perr = p;
`endif
               m_word = w;
               m_val  = 1'b1;
               pulse_cyc.push_back(cyc);
               pulse_word.push_back(w);
               q_bits.delete();
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk_i) begin
      if (cyc > 0) begin
         check("cyc_data", 64'(deser_data_o), 64'(m_word));
         check("cyc_val", 64'(deser_data_val_o), 64'(m_val));
         check("cyc_busy", 64'(busy_o), 64'(q_bits.size() != 0));
`ifdef DESERIALIZER_PARITY_EN
         check("cyc_perr", 64'(parity_err_o), 64'(m_perr));
`endif
      end
   end

   task automatic drive(input logic r, input logic v, input logic d);
      @(negedge clk_i);
      #1;
      rst_i      = r;
      data_val_i = v;
      data_i     = d;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w, input int gap, input logic pbit);
      for (int i = DATA_W - 1; i >= 0; i--) begin
         drive(1'b1, 1'b1, w[i]);
         if (i != 0 || FRAME_LEN != DATA_W)
            for (int g = 0; g < gap; g++) drive(1'b1, 1'b0, 1'b0);
      end
`ifdef DESERIALIZER_PARITY_EN
      drive(1'b1, 1'b1, pbit);
`else
      if (pbit) ; // parity bit has no meaning without the parity build
`endif
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      // Reset state
      #1;
      check("rst_data", 64'(deser_data_o), 64'h0);
      check("rst_val", 64'(deser_data_val_o), 64'h0);
      check("rst_busy", 64'(busy_o), 64'h0);
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);

      // Single frame 0xA5C3 back-to-back
      send_word(16'hA5C3, 0, ^16'hA5C3);
      drive(1'b1, 1'b0, 1'b0);
      check("s1_pulse", 64'(deser_data_val_o), 64'h1);
      check("s1_data", 64'(deser_data_o), 64'hA5C3);
      drive(1'b1, 1'b0, 1'b0);
      check("s1_single", 64'(deser_data_val_o), 64'h0);
      check("s1_hold", 64'(deser_data_o), 64'hA5C3);
      check("s1_count", 64'(pulse_word.size()), 64'd1);

      // Gapped frame 0x8001; busy must hold through the gaps
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      check("gap_busy_first", 64'(busy_o), 64'h1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      for (int i = DATA_W - 2; i >= 0; i--) begin
         drive(1'b1, 1'b1, (i == 0) ? 1'b1 : 1'b0);
         if (i != 0 || FRAME_LEN != DATA_W)
            for (int g = 0; g < 3; g++) drive(1'b1, 1'b0, 1'b0);
         if (i == 1) check("gap_busy_mid", 64'(busy_o), 64'h1);
      end
`ifdef DESERIALIZER_PARITY_EN
      drive(1'b1, 1'b1, 1'b0);
`endif
      drive(1'b1, 1'b0, 1'b0);
      check("gap_data", 64'(deser_data_o), 64'h8001);
      check("gap_pulse", 64'(deser_data_val_o), 64'h1);
      check("gap_idle", 64'(busy_o), 64'h0);

      // Back-to-back frames 0x1234 then 0xFFFF
      n = pulse_word.size();
      send_word(16'h1234, 0, ^16'h1234);
      send_word(16'hFFFF, 0, ^16'hFFFF);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      check("b2b_count", 64'(pulse_word.size() - n), 64'd2);
      check("b2b_w0", 64'(pulse_word[n]), 64'h1234);
      check("b2b_w1", 64'(pulse_word[n+1]), 64'hFFFF);
      check("b2b_spacing", 64'(pulse_cyc[n+1] - pulse_cyc[n]), 64'(FRAME_LEN));
      check("b2b_last", 64'(deser_data_o), 64'hFFFF);

      // Reset after 7 bits aborts the frame asynchronously
      n = pulse_word.size();
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      #1;
      check("arst_data", 64'(deser_data_o), 64'h0);
      check("arst_busy", 64'(busy_o), 64'h0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      send_word(16'h00FF, 0, ^16'h00FF);
      drive(1'b1, 1'b0, 1'b0);
      check("rst_frame_data", 64'(deser_data_o), 64'h00FF);
      check("rst_frame_count", 64'(pulse_word.size() - n), 64'd1);
      drive(1'b1, 1'b0, 1'b0);

`ifdef DESERIALIZER_PARITY_EN
      // Even parity: good bit then bad bit
      send_word(16'h0001, 0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      check("par_ok_val", 64'(deser_data_val_o), 64'h1);
      check("par_ok_err", 64'(parity_err_o), 64'h0);
      send_word(16'h0001, 0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      check("par_bad_val", 64'(deser_data_val_o), 64'h1);
      check("par_bad_err", 64'(parity_err_o), 64'h1);
      drive(1'b1, 1'b0, 1'b0);
      check("par_bad_clear", 64'(parity_err_o), 64'h0);
`endif

      repeat (3) drive(1'b1, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
